// File: rtl/axi_ar_decoder_ordered_if.sv
// AR-channel decoder bundle: master request, target fan-out, window config and error handshake.
interface axi_ar_decoder_ordered_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned LOG_N_INIT  = 3,
  parameter int unsigned N_REGION    = 4,
  parameter int unsigned CNT_WIDTH   = 4
);
  logic                                                  arvalid_i;
  logic [ADDR_WIDTH-1:0]                                 araddr_i;
  logic                                                  arready_o;
  logic [N_INIT_PORT-1:0]                                arvalid_o;
  logic [N_INIT_PORT-1:0]                                arready_i;
  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]  START_ADDR_i;
  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]  END_ADDR_i;
  logic [N_REGION-1:0][N_INIT_PORT-1:0]                  enable_region_i;
  logic [N_INIT_PORT-1:0]                                connectivity_map_i;
  logic                                                  rdone_i;
  logic                                                  error_req_o;
  logic                                                  error_gnt_i;
  logic                                                  sample_ardata_info_o;
  logic [LOG_N_INIT-1:0]                                 cur_target_o;
  logic [CNT_WIDTH-1:0]                                  outstanding_o;
  logic                                                  busy_o;

  modport slave (
    input  arvalid_i, araddr_i, arready_i, START_ADDR_i, END_ADDR_i, enable_region_i,
           connectivity_map_i, rdone_i, error_gnt_i,
    output arready_o, arvalid_o, error_req_o, sample_ardata_info_o, cur_target_o,
           outstanding_o, busy_o
  );

  modport master (
    output arvalid_i, araddr_i, arready_i, START_ADDR_i, END_ADDR_i, enable_region_i,
           connectivity_map_i, rdone_i, error_gnt_i,
    input  arready_o, arvalid_o, error_req_o, sample_ardata_info_o, cur_target_o,
           outstanding_o, busy_o
  );
endinterface

// File: rtl/axi_ar_decoder_ordered.sv
// AR address decoder with single-target ordering lock, outstanding-read tracking and a
// sequenced accept/drain/request path for unmapped addresses.
module axi_ar_decoder_ordered #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned N_INIT_PORT     = 8,
  parameter int unsigned LOG_N_INIT      = 3,
  parameter int unsigned N_REGION        = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  axi_ar_decoder_ordered_if.slave bus
);

  typedef enum logic [1:0] {
    StOperative = 2'd0,
    StErrDrain  = 2'd1,
    StErrReq    = 2'd2
  } state_e;

  state_e                 r_state, w_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_d;
  logic [LOG_N_INIT-1:0]  r_cur, w_cur_d;

  logic [N_INIT_PORT-1:0] w_hit;
  logic [LOG_N_INIT-1:0]  w_sel;
  logic                   w_miss;
  logic                   w_stall;
  logic                   w_hs;
  logic                   w_dec;

  always_comb begin
    w_hit = '0;
    for (int r = 0; r < int'(N_REGION); r++) begin
      for (int j = 0; j < int'(N_INIT_PORT); j++) begin
        if (bus.enable_region_i[r][j] &&
            (bus.araddr_i >= bus.START_ADDR_i[r][j]) &&
            (bus.araddr_i <= bus.END_ADDR_i[r][j])) begin
          w_hit[j] = 1'b1;
        end
      end
    end
    w_hit = w_hit & bus.connectivity_map_i;
  end

  // Descending scan so the lowest matching index is the one left in w_sel.
  always_comb begin
    w_sel = '0;
    for (int j = int'(N_INIT_PORT) - 1; j >= 0; j--) begin
      if (w_hit[j]) w_sel = LOG_N_INIT'(j);
    end
  end

  assign w_miss  = ~|w_hit;
  assign w_stall = ((r_cnt != '0) && (w_sel != r_cur)) ||
                   (r_cnt == CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_dec   = bus.rdone_i && (r_cnt != '0);

  always_comb begin
    w_state_d                = r_state;
    w_hs                     = 1'b0;
    bus.arvalid_o            = '0;
    bus.arready_o            = 1'b0;
    bus.sample_ardata_info_o = 1'b0;
    bus.error_req_o          = 1'b0;
    unique case (r_state)
      StOperative: begin
        if (bus.arvalid_i) begin
          if (w_miss) begin
            bus.arready_o            = 1'b1;
            bus.sample_ardata_info_o = 1'b1;
            w_state_d                = StErrDrain;
          end else if (!w_stall) begin
            bus.arvalid_o[w_sel] = 1'b1;
            bus.arready_o        = bus.arready_i[w_sel];
            w_hs                 = bus.arready_i[w_sel];
          end
        end
      end
      StErrDrain: begin
        if (w_cnt_d == '0) w_state_d = StErrReq;
      end
      StErrReq: begin
        bus.error_req_o = 1'b1;
        if (bus.error_gnt_i) w_state_d = StOperative;
      end
      default: w_state_d = StOperative;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_hs && !w_dec) begin
      w_cnt_d = r_cnt + CNT_WIDTH'(1);
    end else if (!w_hs && w_dec) begin
      w_cnt_d = r_cnt - CNT_WIDTH'(1);
    end
    w_cur_d = w_hs ? w_sel : r_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StOperative;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_cur   <= w_cur_d;
    end
  end

  assign bus.cur_target_o  = r_cur;
  assign bus.outstanding_o = r_cnt;
  assign bus.busy_o        = (r_cnt != '0) || (r_state != StOperative);

endmodule
